ext_stream_driver: RTL and testbench
====================================

Name: ext_stream_driver

Overview:
- Host-side master for the matrix multiplier's external (memory-bypass) mode. It drives the multiplier's ext_en/ext_inputs and consumes its ext_result/ext_valid.
- Accepts weight rows and input vectors on valid/ready streams.
- Sequences weight load, input streaming and pipeline flush, and captures results into a result FIFO.
- Sits between a testbench/host DMA and the multiplier's external port.

Parameters:
- WIDTH, 8, element width in bits
- ROW, 4, systolic rows; number of weight rows loaded per job
- COL, 4, systolic columns
- MAX_VEC, 64, maximum input vectors per job
- RES_DEPTH, 64, result FIFO depth (power of 2)
- FLUSH_MAX, ROW+COL+2, flush cycle limit before timeout

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- start_i  in  1  job start pulse; sampled only in IDLE
- vec_count_i  in  $clog2(MAX_VEC+1)  input vectors in the job; sampled on start
- w_valid_i / w_ready_o  in/out  1  weight stream handshake
- w_data_i  in  COL*WIDTH  weight row
- in_valid_i / in_ready_o  in/out  1  input stream handshake
- in_data_i  in  ROW*WIDTH  input vector
- ext_en_o  out  1  external-mode enable to multiplier
- ext_input_o  out  ROW*WIDTH  to ext_input
- ext_weight_o  out  COL*WIDTH  to ext_weight
- ext_weight_en_o  out  1  to ext_weight_en
- ext_valid_o  out  1  to ext_valid
- ext_result_i  in  COL*WIDTH  from ext_result
- ext_valid_i  in  1  from multiplier ext_valid
- res_valid_o / res_ready_i  out/in  1  result stream handshake
- res_data_o  out  COL*WIDTH  FIFO head
- busy_o  out  1  high when not in IDLE
- done_o  out  1  one-cycle pulse at job end
- underrun_o, overflow_o, timeout_o  out  1 each  sticky error flags, cleared on accepted start

Behaviour:
- Reset: every output is 0, FIFO is empty, state is IDLE. Reset mid-job aborts immediately; no done pulse. All ext_* outputs are registered.
- States: IDLE -> LOAD_W -> GAP -> STREAM -> FLUSH -> DONE -> IDLE.
- IDLE:
  - start_i=1 latches vec_count_i into vcnt, clears the error flags and goes to LOAD_W.
  - ext_en_o=0, w_ready_o=0, in_ready_o=0.
- LOAD_W:
  - ext_en_o=1 and w_ready_o=1.
  - Each w_valid_i&w_ready_o handshake registers ext_weight_o<=w_data_i and pulses ext_weight_en_o=1 the following cycle.
  - Cycles without a handshake drive ext_weight_en_o=0.
  - After ROW handshakes, go to GAP.
- GAP: one cycle with ext_weight_en_o=0 and ext_valid_o=0. Next state is STREAM, or FLUSH if vcnt==0.
- STREAM:
  - ext_valid_o=1 every cycle, contiguously; the multiplier's row counter must not reset.
  - in_ready_o=1. On a handshake, ext_input_o<=in_data_i.
  - If in_valid_i=0, drive ext_input_o<=0 with ext_valid_o still 1, set underrun_o, and count the cycle as an issued vector.
  - After vcnt issued vectors, go to FLUSH.
- FLUSH:
  - ext_valid_o=1 and ext_input_o=0; in_ready_o=0.
  - Exit to DONE when captured==vcnt.
  - If FLUSH_MAX cycles elapse first, set timeout_o and exit to DONE.
- DONE: ext_valid_o=0, done_o=1 for one cycle, then IDLE. ext_en_o stays 1 through DONE and drops in IDLE.
- Capture (STREAM and FLUSH only):
  - Each cycle with ext_valid_i=1 and captured<vcnt pushes ext_result_i into the FIFO and increments captured.
  - ext_valid_i beyond vcnt, or outside STREAM/FLUSH, is ignored.
  - Push when the FIFO is full: data dropped, overflow_o set, captured still increments.
- FIFO:
  - res_valid_o = !empty; pop on res_valid_o&res_ready_i.
  - Simultaneous push and pop when full is permitted: the pop frees the slot, no overflow.
  - Pointers wrap modulo RES_DEPTH. The FIFO is not cleared by start; it drains across jobs.
- Counters: issued and captured are $clog2(MAX_VEC+1) bits. vec_count_i>MAX_VEC saturates to MAX_VEC.
- start_i outside IDLE is ignored.

Test Plan:
- ROW=COL=4, WIDTH=8. Bench stub returns ext_valid_i with data = ext_input sum broadcast to all columns, ROW cycles after each ext_valid_o. Stimulus: vec_count=3, weights 0x01 x4 rows, inputs {1,2,3,4},{5,6,7,8},{0,0,0,1}. Required: ext_weight_en_o high exactly 4 cycles; ext_valid_o high 3+flush cycles, contiguous; FIFO yields 10,26,1 per column; done_o pulses once; all flags 0.
- Stimulus: in_valid_i dropped for 1 cycle mid-STREAM (vec_count=4). Required: ext_valid_o stays high, a zero vector is issued, underrun_o=1, exactly 4 results captured.
- Stimulus: res_ready_i=0 with RES_DEPTH=4 and vec_count=6. Required: 4 results stored, overflow_o=1, done_o still pulses; after draining, res_valid_o=0.
- Stimulus: stub never asserts ext_valid_i, vec_count=2. Required: FLUSH lasts exactly FLUSH_MAX=10 cycles, timeout_o=1, done_o pulses, FIFO empty.
- Stimulus: rst_i asserted during LOAD_W after 2 weight handshakes. Required: next cycle all outputs 0 and state IDLE. A fresh start then needs 4 new weight handshakes.
- Stimulus: vec_count=0. Required: 4 weight loads, GAP, then 0 STREAM cycles; FLUSH exits immediately; done_o pulses; no results.

Source files
------------

// File: rtl/ext_stream_driver_if.sv
// rtl/ext_stream_driver_if.sv - stream and multiplier-port bundle for ext_stream_driver
// Purpose: groups the weight/input/result streams and the multiplier external port.
// Signals (direction as seen by the driver, i.e. the master modport):
//   w_valid_i/w_ready_o/w_data_i       weight row stream (COL*WIDTH)
//   in_valid_i/in_ready_o/in_data_i    input vector stream (ROW*WIDTH)
//   ext_en_o, ext_input_o, ext_weight_o, ext_weight_en_o, ext_valid_o   to multiplier
//   ext_result_i, ext_valid_i          from multiplier
//   res_valid_o/res_ready_i/res_data_o result stream (FIFO head)
interface ext_stream_driver_if #(
    parameter int WIDTH = 8,
    parameter int ROW   = 4,
    parameter int COL   = 4
);
    logic                   w_valid_i;
    logic                   w_ready_o;
    logic [COL*WIDTH-1:0]   w_data_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [ROW*WIDTH-1:0]   in_data_i;
    logic                   ext_en_o;
    logic [ROW*WIDTH-1:0]   ext_input_o;
    logic [COL*WIDTH-1:0]   ext_weight_o;
    logic                   ext_weight_en_o;
    logic                   ext_valid_o;
    logic [COL*WIDTH-1:0]   ext_result_i;
    logic                   ext_valid_i;
    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [COL*WIDTH-1:0]   res_data_o;

    modport master (
        input  w_valid_i, w_data_i, in_valid_i, in_data_i,
               ext_result_i, ext_valid_i, res_ready_i,
        output w_ready_o, in_ready_o, ext_en_o, ext_input_o, ext_weight_o,
               ext_weight_en_o, ext_valid_o, res_valid_o, res_data_o
    );

    modport slave (
        output w_valid_i, w_data_i, in_valid_i, in_data_i,
               ext_result_i, ext_valid_i, res_ready_i,
        input  w_ready_o, in_ready_o, ext_en_o, ext_input_o, ext_weight_o,
               ext_weight_en_o, ext_valid_o, res_valid_o, res_data_o
    );
endinterface

// File: rtl/ext_stream_driver.sv
// rtl/ext_stream_driver.sv - host-side sequencer for the matrix multiplier external mode
// Purpose: loads ROW weight rows, streams vec_count input vectors, flushes the
// pipeline and captures results into a FIFO.
// Ports: clk_i, rst_i (sync, active high), start_i, vec_count_i,
//   bus (ext_stream_driver_if.master: streams + multiplier port),
//   busy_o, done_o, underrun_o, overflow_o, timeout_o (sticky, cleared on start).
module ext_stream_driver #(
    parameter int WIDTH     = 8,
    parameter int ROW       = 4,
    parameter int COL       = 4,
    parameter int MAX_VEC   = 64,
    parameter int RES_DEPTH = 64,
    parameter int FLUSH_MAX = ROW + COL + 2,
    parameter int CW        = $clog2(MAX_VEC + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [CW-1:0]          vec_count_i,
    ext_stream_driver_if.master    bus,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   underrun_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);
    localparam int WCW = $clog2(ROW + 1);
    localparam int FCW = $clog2(FLUSH_MAX + 1);
    localparam int AW  = $clog2(RES_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_GAP, S_STREAM, S_FLUSH, S_DONE
    } state_t;

    state_t               r_state, w_next;
    logic [CW-1:0]        r_vcnt, r_issued, r_captured;
    logic [WCW-1:0]       r_wcnt;
    logic [FCW-1:0]       r_fcnt;
    logic                 r_ext_en, r_ext_weight_en, r_ext_valid;
    logic [ROW*WIDTH-1:0] r_ext_input;
    logic [COL*WIDTH-1:0] r_ext_weight;
    logic                 r_underrun, r_overflow, r_timeout;
    logic [AW:0]          r_wr_ptr, r_rd_ptr;
    logic [COL*WIDTH-1:0] r_mem [RES_DEPTH];

    logic                 w_w_hs, w_capture, w_empty, w_full, w_pop, w_push, w_drop;
    logic                 w_timeout_evt;
    logic [CW-1:0]        w_vcnt_sat;

    assign w_w_hs     = (r_state == S_LOAD_W) && bus.w_valid_i;
    assign w_capture  = ((r_state == S_STREAM) || (r_state == S_FLUSH)) &&
                        bus.ext_valid_i && (r_captured < r_vcnt);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop      = !w_empty && bus.res_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push     = w_capture && (!w_full || w_pop);
    assign w_drop     = w_capture && w_full && !w_pop;
    assign w_vcnt_sat = (vec_count_i > CW'(MAX_VEC)) ? CW'(MAX_VEC) : vec_count_i;

    always_comb begin
        w_next        = r_state;
        w_timeout_evt = 1'b0;
        case (r_state)
            S_IDLE:   if (start_i) w_next = S_LOAD_W;
            S_LOAD_W: if (w_w_hs && (r_wcnt == WCW'(ROW - 1))) w_next = S_GAP;
            S_GAP:    w_next = (r_vcnt == '0) ? S_FLUSH : S_STREAM;
            S_STREAM: if (r_issued + CW'(1) == r_vcnt) w_next = S_FLUSH;
            S_FLUSH: begin
                if (r_captured == r_vcnt) begin
                    w_next = S_DONE;
                end else if (r_fcnt == FCW'(FLUSH_MAX - 1)) begin
                    w_next        = S_DONE;
                    w_timeout_evt = 1'b1;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state         <= S_IDLE;
            r_vcnt          <= '0;
            r_issued        <= '0;
            r_captured      <= '0;
            r_wcnt          <= '0;
            r_fcnt          <= '0;
            r_ext_en        <= 1'b0;
            r_ext_weight_en <= 1'b0;
            r_ext_valid     <= 1'b0;
            r_ext_input     <= '0;
            r_ext_weight    <= '0;
            r_underrun      <= 1'b0;
            r_overflow      <= 1'b0;
            r_timeout       <= 1'b0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && start_i) begin
                r_vcnt     <= w_vcnt_sat;
                r_underrun <= 1'b0;
                r_overflow <= 1'b0;
                r_timeout  <= 1'b0;
            end
            r_wcnt     <= (r_state == S_IDLE) ? '0 : (w_w_hs ? r_wcnt + WCW'(1) : r_wcnt);
            r_issued   <= (r_state == S_IDLE) ? '0 :
                          ((r_state == S_STREAM) ? r_issued + CW'(1) : r_issued);
            r_captured <= (r_state == S_IDLE) ? '0 : (w_capture ? r_captured + CW'(1) : r_captured);
            r_fcnt     <= (r_state == S_FLUSH) ? r_fcnt + FCW'(1) : '0;

            // Outputs are registered; ext_en follows the next state so it is
            // high exactly from LOAD_W through DONE.
            r_ext_en        <= (w_next != S_IDLE);
            r_ext_weight_en <= w_w_hs;
            if (w_w_hs) r_ext_weight <= bus.w_data_i;
            // Each STREAM cycle issues one vector next cycle (a zero vector on
            // underrun); FLUSH keeps valid high with zero data until it exits.
            r_ext_valid <= (r_state == S_STREAM) ||
                           ((r_state == S_FLUSH) && (w_next == S_FLUSH));
            r_ext_input <= ((r_state == S_STREAM) && bus.in_valid_i) ? bus.in_data_i : '0;

            if ((r_state == S_STREAM) && !bus.in_valid_i) r_underrun <= 1'b1;
            if (w_drop)        r_overflow <= 1'b1;
            if (w_timeout_evt) r_timeout  <= 1'b1;

            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.ext_result_i;
    end

    assign bus.w_ready_o       = (r_state == S_LOAD_W);
    assign bus.in_ready_o      = (r_state == S_STREAM);
    assign bus.ext_en_o        = r_ext_en;
    assign bus.ext_input_o     = r_ext_input;
    assign bus.ext_weight_o    = r_ext_weight;
    assign bus.ext_weight_en_o = r_ext_weight_en;
    assign bus.ext_valid_o     = r_ext_valid;
    assign bus.res_valid_o     = !w_empty;
    assign bus.res_data_o      = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign busy_o              = (r_state != S_IDLE);
    assign done_o              = (r_state == S_DONE);
    assign underrun_o          = r_underrun;
    assign overflow_o          = r_overflow;
    assign timeout_o           = r_timeout;
endmodule

// File: tb/tb_ext_stream_driver.sv
// tb/tb_ext_stream_driver.sv - self-checking bench for ext_stream_driver
module tb_ext_stream_driver;
    localparam int WIDTH     = 8;
    localparam int ROW       = 4;
    localparam int COL       = 4;
    localparam int MAX_VEC   = 64;
    localparam int RES_DEPTH = 4;
    localparam int FLUSH_MAX = ROW + COL + 2;
    localparam int CW        = $clog2(MAX_VEC + 1);

    logic          clk = 1'b0;
    logic          rst, start;
    logic [CW-1:0] vec_count;
    logic          busy, done, underrun, overflow, timeout;

    always #5 clk = ~clk;

    ext_stream_driver_if #(.WIDTH(WIDTH), .ROW(ROW), .COL(COL)) bus ();

    ext_stream_driver #(
        .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .MAX_VEC(MAX_VEC),
        .RES_DEPTH(RES_DEPTH), .FLUSH_MAX(FLUSH_MAX)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .vec_count_i(vec_count),
        .bus(bus), .busy_o(busy), .done_o(done), .underrun_o(underrun),
        .overflow_o(overflow), .timeout_o(timeout)
    );

    int passed = 0;
    int total  = 0;

    logic [COL*WIDTH-1:0] wq[$];
    int                   w_rd = 0;
    bit                   w_pend = 0;
    logic [ROW*WIDTH-1:0] sq[$];
    bit                   sb[$];
    int                   s_rd = 0;
    bit                   s_pend = 0;

    int  we_cnt = 0, ev_rises = 0, done_cnt = 0, busy_cnt = 0, w_hs = 0;
    bit  ev_prev = 0;
    bit  stub_en = 1;
    logic [ROW*WIDTH-1:0] mon_in[$];
    logic [COL*WIDTH-1:0] mon_w[$];
    logic [COL*WIDTH-1:0] res_q[$];
    logic [COL*WIDTH:0]   pipe [0:ROW];

    function automatic logic [WIDTH-1:0] vsum(input logic [ROW*WIDTH-1:0] v);
        logic [WIDTH-1:0] s;
        s = '0;
        for (int i = 0; i < ROW; i++) s = s + v[i*WIDTH +: WIDTH];
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Multiplier stub: each issued vector returns its element sum on every
    // column ROW cycles later.
    initial begin
        bus.ext_valid_i  = 1'b0;
        bus.ext_result_i = '0;
        for (int i = 0; i <= ROW; i++) pipe[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = ROW; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = {bus.ext_valid_o, {COL{vsum(bus.ext_input_o)}}};
            bus.ext_valid_i  = stub_en && pipe[ROW][COL*WIDTH];
            bus.ext_result_i = pipe[ROW][COL*WIDTH-1:0];
        end
    end

    // Stream feeders and output monitor, all at the falling edge.
    initial begin
        bus.w_valid_i  = 1'b0;
        bus.w_data_i   = '0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.ext_weight_en_o) begin
                we_cnt++;
                mon_w.push_back(bus.ext_weight_o);
            end
            if (bus.ext_valid_o) begin
                mon_in.push_back(bus.ext_input_o);
                if (!ev_prev) ev_rises++;
            end
            ev_prev = bus.ext_valid_o;
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (bus.res_valid_o && bus.res_ready_i) res_q.push_back(bus.res_data_o);

            if (w_pend) begin w_rd++; w_hs++; end
            bus.w_valid_i = (w_rd < wq.size());
            bus.w_data_i  = bus.w_valid_i ? wq[w_rd] : '0;
            w_pend        = bus.w_valid_i && bus.w_ready_o;

            if (s_pend) s_rd++;
            if (s_rd < sq.size()) begin
                bus.in_valid_i = !sb[s_rd];
                bus.in_data_i  = sb[s_rd] ? '0 : sq[s_rd];
                s_pend         = bus.in_ready_o;
            end else begin
                bus.in_valid_i = 1'b0;
                bus.in_data_i  = '0;
                s_pend         = 1'b0;
            end
        end
    end

    task automatic push_weights();
        for (int i = 0; i < ROW; i++) wq.push_back($urandom);
    endtask

    task automatic push_slot(input logic [ROW*WIDTH-1:0] d, input bit bub);
        sq.push_back(d);
        sb.push_back(bub);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ctl"}, {bus.w_ready_o, bus.in_ready_o, bus.ext_en_o, bus.ext_weight_en_o,
                           bus.ext_valid_o, bus.res_valid_o, busy, done, underrun, overflow,
                           timeout}, 0);
        chk({tag, "_data"}, bus.ext_input_o | bus.ext_weight_o | bus.res_data_o, 0);
    endtask

    task automatic run_job(input string tag, input int vc_in, input bit stub_on);
        int  exp_vc, s0, we0, done0, busy0, rise0, in0, res0, nres, k, bad;
        bit  any_bub;
        logic [ROW*WIDTH-1:0] v;
        logic [COL*WIDTH-1:0] exp_res[$];
        exp_vc = (vc_in > MAX_VEC) ? MAX_VEC : vc_in;
        s0 = s_rd; we0 = we_cnt; done0 = done_cnt; busy0 = busy_cnt;
        rise0 = ev_rises; in0 = mon_in.size(); res0 = res_q.size();
        stub_en   = stub_on;
        vec_count = CW'(vc_in);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        k = 0;
        while (done_cnt == done0 && k < 400) begin tick(); k++; end
        chk({tag, "_done_seen"}, k < 400, 1);
        tick(3);
        chk({tag, "_done_pulses"}, done_cnt - done0, 1);
        chk({tag, "_weight_en_cycles"}, we_cnt - we0, ROW);
        bad = 0;
        for (int i = 0; i < ROW; i++)
            if (mon_w[mon_w.size()-ROW+i] !== wq[w_rd-ROW+i]) bad++;
        chk({tag, "_weights"}, bad, 0);
        chk({tag, "_vectors_taken"}, s_rd - s0, exp_vc);
        any_bub = 0;
        bad = 0;
        for (int i = 0; i < exp_vc; i++) begin
            v = sb[s0+i] ? '0 : sq[s0+i];
            any_bub |= sb[s0+i];
            if (in0 + i >= mon_in.size() || mon_in[in0+i] !== v) bad++;
            exp_res.push_back({COL{vsum(v)}});
        end
        for (int i = in0 + exp_vc; i < mon_in.size(); i++)
            if (mon_in[i] !== '0) bad++;
        chk({tag, "_issued_inputs"}, bad, 0);
        chk({tag, "_valid_bursts"}, ev_rises - rise0, (exp_vc > 0) ? 1 : 0);
        chk({tag, "_underrun"}, underrun, any_bub);
        chk({tag, "_overflow"}, overflow, stub_on && exp_vc > RES_DEPTH);
        chk({tag, "_timeout"}, timeout, !stub_on && exp_vc > 0);
        if (!stub_on || exp_vc == 0)
            chk({tag, "_busy_cycles"}, busy_cnt - busy0,
                ROW + 1 + exp_vc + ((exp_vc == 0) ? 1 : FLUSH_MAX) + 1);
        bus.res_ready_i = 1'b1;
        k = 0;
        while (bus.res_valid_o && k < 200) begin tick(); k++; end
        bus.res_ready_i = 1'b0;
        tick();
        nres = stub_on ? ((exp_vc > RES_DEPTH) ? RES_DEPTH : exp_vc) : 0;
        chk({tag, "_result_count"}, res_q.size() - res0, nres);
        bad = 0;
        for (int i = 0; i < nres && res0 + i < res_q.size(); i++)
            if (res_q[res0+i] !== exp_res[i]) bad++;
        chk({tag, "_result_data"}, bad, 0);
        chk({tag, "_fifo_empty"}, bus.res_valid_o, 0);
        tick(6);
    endtask

    initial begin
        int k, hs0, done0, vc;
        rst = 1'b1; start = 1'b0; vec_count = '0; bus.res_ready_i = 1'b0;
        tick(3);
        chk_zero_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Basic job: unit weights, sums 10, 26, 1.
        for (int i = 0; i < ROW; i++) wq.push_back({COL{8'h01}});
        push_slot(32'h04030201, 0);
        push_slot(32'h08070605, 0);
        push_slot(32'h01000000, 0);
        run_job("basic", 3, 1);
        chk("basic_sum0", res_q[res_q.size()-3], {COL{8'd10}});
        chk("basic_sum2", res_q[res_q.size()-1], {COL{8'd1}});

        // One-cycle input bubble mid-stream.
        push_weights();
        push_slot($urandom, 0); push_slot($urandom, 0);
        push_slot('0, 1);       push_slot($urandom, 0);
        run_job("underrun", 4, 1);

        // Results held back: depth-4 FIFO overflows on 6 results.
        push_weights();
        for (int i = 0; i < 6; i++) push_slot($urandom, 0);
        run_job("overflow", 6, 1);

        // Multiplier silent: flush times out.
        push_weights();
        push_slot($urandom, 0); push_slot($urandom, 0);
        run_job("timeout", 2, 0);

        // Reset after two weight handshakes aborts the job.
        wq.push_back($urandom); wq.push_back($urandom);
        done0 = done_cnt; hs0 = w_hs;
        vec_count = CW'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (w_hs - hs0 < 2 && k < 50) begin tick(); k++; end
        chk("rst_two_handshakes", w_hs - hs0, 2);
        tick(2);
        rst = 1'b1;
        tick();
        chk_zero_outputs("midjob_reset");
        rst = 1'b0;
        tick(2);
        chk("rst_no_done", done_cnt - done0, 0);
        push_weights();
        for (int i = 0; i < 3; i++) push_slot($urandom, 0);
        run_job("after_reset", 3, 1);

        // Empty job.
        push_weights();
        run_job("zero_vec", 0, 1);

        // Randomized jobs.
        for (int j = 0; j < 3; j++) begin
            vc = $urandom_range(7, 1);
            push_weights();
            for (int i = 0; i < vc; i++) push_slot($urandom, ($urandom_range(3, 0) == 0));
            run_job($sformatf("rand%0d", j), vc, 1);
        end

        // Oversized count saturates to MAX_VEC; extra vectors stay unconsumed.
        push_weights();
        for (int i = 0; i < MAX_VEC + 6; i++) push_slot($urandom, 0);
        run_job("saturate", 100, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
